// File: rtl/vc_lru_ctrl_pkg.sv
// Shared victim-cache LRU types: geometry constants, way/stack types, op and FSM state enums.
// Used by vc_lru_ctrl, vc_lru_reorder and the L2 LRU logic.
package lc3b_types;

  localparam int VC_WAYS = 8;
  localparam int VC_IDXW = 3;
  localparam int VC_LRUW = VC_WAYS * VC_IDXW;

  typedef logic [VC_IDXW-1:0] vc_way_t;
  typedef logic [VC_LRUW-1:0] vc_lru_t;

  typedef enum logic {
    VC_TOUCH  = 1'b0,
    VC_VICTIM = 1'b1
  } vc_lru_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } vc_lru_state_t;

endpackage

// File: rtl/vc_lru_ctrl_if.sv
// Request and LRU-array bus between the VC control FSM (master) and vc_lru_ctrl (slave).
// Handshake: req is sampled only while busy=0; once taken, ack pulses for one cycle on completion,
// and lru_wdata is meaningful only in the cycle lru_write=1.
interface vc_lru_ctrl_if #(
  parameter int IDXW = lc3b_types::VC_IDXW,
  parameter int LRUW = lc3b_types::VC_LRUW
);
  logic            req;
  logic            op;
  logic [IDXW-1:0] way_in;
  logic            busy;
  logic            ack;
  logic [IDXW-1:0] victim_way;
  logic [LRUW-1:0] lru_rdata;
  logic            lru_write;
  logic [LRUW-1:0] lru_wdata;

  modport master (
    output req, op, way_in, lru_rdata,
    input  busy, ack, victim_way, lru_write, lru_wdata
  );

  modport slave (
    input  req, op, way_in, lru_rdata,
    output busy, ack, victim_way, lru_write, lru_wdata
  );
endinterface

// File: rtl/vc_lru_reorder.sv
// Combinational LRU stack reorder: move target to slot 0 and shift slots 0..pos-1 down by one.
// Slots above pos are untouched; shared with the L2 LRU logic.
module vc_lru_reorder #(
  parameter int WAYS = 8,
  parameter int IDXW = 3,
  localparam int LRUW = WAYS * IDXW
) (
  input  logic [LRUW-1:0] stk,
  input  logic [IDXW-1:0] pos,
  input  logic [IDXW-1:0] target,
  output logic [LRUW-1:0] new_stk
);

  always_comb begin
    new_stk = stk;
    new_stk[IDXW-1:0] = target;
    for (int k = 1; k < WAYS; k++) begin
      if (k <= int'(pos)) begin
        new_stk[k*IDXW +: IDXW] = stk[(k-1)*IDXW +: IDXW];
      end
    end
  end

endmodule

// File: rtl/vc_lru_ctrl.sv
// Victim-cache LRU read/update controller: touch (make way MRU) and victim (return LRU way, make it MRU).
// Optional statistics (touch/victim counters, sticky stack_err) are built when VC_LRU_STATS_EN is defined.
module vc_lru_ctrl
  import lc3b_types::*;
#(
  parameter int WAYS = VC_WAYS,
  parameter int IDXW = VC_IDXW,
  localparam int LRUW = WAYS * IDXW
) (
  input  logic          clk,
  input  logic          rst,
  vc_lru_ctrl_if.slave  bus,
  output vc_lru_state_t state_dbg
`ifdef VC_LRU_STATS_EN
  ,
  output logic [15:0]   touch_cnt,
  output logic [15:0]   victim_cnt,
  output logic          stack_err
`endif
);

  vc_lru_state_t   state, state_nxt;
  vc_lru_op_t      op_q;
  logic [IDXW-1:0] tgt_q;
  logic [LRUW-1:0] stk_q;
  logic [IDXW-1:0] pos_q;
  logic [IDXW-1:0] pos_c;
  logic [IDXW-1:0] victim_q;
  logic [LRUW-1:0] wdata_q;
  logic [LRUW-1:0] new_stk;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = SEARCH;
      SEARCH:  state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; lru_write decodes straight from state so reset drops it without a clock edge
  always_comb begin
    state_dbg      = state;
    bus.busy       = (state != IDLE);
    bus.ack        = (state == DONE);
    bus.lru_write  = (state == WRITE);
    bus.lru_wdata  = (state == WRITE) ? new_stk : wdata_q;
    bus.victim_way = victim_q;
  end

  // Lowest matching slot wins; a corrupt stack with no match falls back to the LRU slot
  always_comb begin
    pos_c = IDXW'(WAYS - 1);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (stk_q[i*IDXW +: IDXW] == tgt_q) pos_c = IDXW'(i);
    end
  end

  vc_lru_reorder #(.WAYS(WAYS), .IDXW(IDXW)) u_reorder (
    .stk     (stk_q),
    .pos     (pos_q),
    .target  (tgt_q),
    .new_stk (new_stk)
  );

  // Victim target is resolved at request time, so SEARCH treats both ops identically
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= VC_TOUCH;
      tgt_q    <= '0;
      stk_q    <= '0;
      pos_q    <= '0;
      victim_q <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            op_q  <= vc_lru_op_t'(bus.op);
            tgt_q <= bus.op ? bus.lru_rdata[LRUW-1 -: IDXW] : bus.way_in;
            stk_q <= bus.lru_rdata;
          end
        end
        SEARCH: begin
          pos_q <= pos_c;
          if (op_q == VC_VICTIM) victim_q <= tgt_q;
        end
        WRITE:   wdata_q <= new_stk;
        default: ;
      endcase
    end
  end

`ifdef VC_LRU_STATS_EN
  logic hit_c;

  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (stk_q[i*IDXW +: IDXW] == tgt_q) hit_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      touch_cnt  <= '0;
      victim_cnt <= '0;
      stack_err  <= 1'b0;
    end else begin
      if (state == SEARCH && !hit_c) stack_err <= 1'b1;
      if (state == DONE) begin
        if (op_q == VC_VICTIM) victim_cnt <= victim_cnt + 16'd1;
        else                   touch_cnt  <= touch_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/vc_lru_ctrl.md
Name: vc_lru_ctrl

Overview:
- Read/update controller for the victim-cache LRU state register, which is 24 bits wide with 8 ways × 3-bit way indices.
- Reads the current LRU stack and services two kinds of request from the VC datapath:
  - touch: mark a way most-recently-used.
  - victim: return the LRU way and promote it to MRU.
- Writes the reordered stack back through the array's write/datain port.
- Sits between the victim-cache control FSM and the LRU storage register.

Parameters:
- WAYS, 8, number of victim-cache ways (power of two).
- IDXW, 3, way-index width, equal to log2(WAYS).
- LRUW, 24, stack width, equal to WAYS*IDXW (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  1  request valid; sampled only in IDLE
- op  in  1  0 = touch, 1 = victim
- way_in  in  IDXW  way to touch; ignored for victim
- busy  out  1  high while a request is in flight (SEARCH, WRITE, DONE)
- ack  out  1  one-cycle completion pulse
- victim_way  out  IDXW  LRU way selected by the last victim op; held until the next victim op
- lru_rdata  in  LRUW  current stack, from the array dataout
- lru_write  out  1  array write enable
- lru_wdata  out  LRUW  new stack, to the array datain

Behaviour:
- Stack encoding:
  - slot[i] = bits [IDXW*i+IDXW-1 : IDXW*i].
  - slot 0 is MRU; slot WAYS-1 is LRU.
  - A legal stack is a permutation of 0..WAYS-1.
  - The power-up stack 111_110_101_100_011_010_001_000 means way 7 is LRU.
- Reset (async, rst=1):
  - state=IDLE, busy=0, ack=0, lru_write=0, lru_wdata=0, victim_way=0.
  - Latched op, way and position registers are cleared.
  - The stack array itself is never reset by this block.
- FSM:
  - IDLE → SEARCH when req=1.
    - Latch op and way_in, and snapshot lru_rdata into stk.
    - For op=1, the target way is stk slot WAYS-1.
  - SEARCH → WRITE.
    - pos = lowest slot index whose content equals the target way.
    - If no slot matches (corrupt stack), pos = WAYS-1.
    - Register pos.
  - WRITE → DONE.
    - lru_write=1 for exactly this cycle.
    - lru_wdata: slot0 = target; slot[k] = stk slot[k-1] for 1≤k≤pos; slot[k] unchanged for k>pos.
    - On op=1, victim_way is updated in this cycle.
  - DONE → IDLE. ack=1 for this cycle only; the array already holds the new stack.
- Latency: req sampled at edge N → lru_write high in cycle N+2 → ack high in cycle N+3. The next req can be accepted at edge N+4.
- req in any non-IDLE state is ignored. The requester holds req until it sees ack, or drops it.
- req held high continuously gives back-to-back ops, one per 4 cycles.
- Touching the current MRU (pos=0): the write still occurs with an unchanged vector, and ack is still produced.
- rst asserted mid-op: returns to IDLE immediately and no ack is produced. If rst hits during WRITE, lru_write drops asynchronously; whether the array captured is undefined only if rst releases on the same edge.
- lru_wdata holds its last value outside WRITE. Only lru_write qualifies it.

Optional Feature:
- Macro VC_LRU_STATS_EN.
- When defined:
  - Adds outputs touch_cnt[15:0] and victim_cnt[15:0].
  - Each increments in DONE for its op type, wraps at 16'hFFFF→0, and is cleared by rst.
  - Adds output stack_err (1 bit), which is sticky and set when SEARCH finds no match.
- When undefined: these ports and logic are absent, and the rest of the block's behaviour is unchanged.

Decomposition:
- Shared package lc3b_types:
  - VC_WAYS, VC_IDXW, VC_LRUW constants.
  - vc_way_t (logic [VC_IDXW-1:0]).
  - vc_lru_t (logic [VC_LRUW-1:0]).
  - Enum vc_lru_op_t {VC_TOUCH, VC_VICTIM}.
  - Enum vc_lru_state_t {IDLE, SEARCH, WRITE, DONE}.
- One sub-module, vc_lru_reorder: combinational (stk, pos, target) → new stack. It is reused by the L2 LRU logic.

Test Plan:
- Reset, then release with no req → busy=0, ack=0, lru_write=0 for 10 cycles; array value stays 24'b111110101100011010001000.
- Victim op on the power-up stack → victim_way=7 in cycle N+2; lru_wdata=111_...→110_101_100_011_010_001_000_111 with lru_write=1; ack at N+3.
- Touch way 3 on the power-up stack → lru_wdata=111_110_101_100_010_001_000_011; ack at N+3.
- Touch way 0 (current MRU) → lru_wdata equals lru_rdata; lru_write and ack still pulse once.
- rst asserted in WRITE cycle → lru_write falls without a clock edge, ack never asserts, state is IDLE; a new req after release completes normally.
- Corrupt stack (all zeros), touch way 5 → pos=7; lru_wdata=000_000_000_000_000_000_000_101; stack_err=1 when VC_LRU_STATS_EN is defined.
